// File: rtl/lcd_page_buffer_if.sv
// Bus between the LCD controller and image ROM (master side) and the page buffer (slave side).
// Carries the page handshake, the streamed column byte and the ROM read port.
interface lcd_page_buffer_if #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 6
);
    logic              data_request;
    logic [ADDR_W-1:0] addr;
    logic              lcd_en;
    logic              data_ack;
    logic [7:0]        data;
    logic [ADDR_W+2:0] rom_addr;
    logic [COLS-1:0]   rom_data;
    logic              busy;

    modport master (
        output data_request, addr, lcd_en, rom_data,
        input  data_ack, data, rom_addr, busy
    );

    modport slave (
        input  data_request, addr, lcd_en, rom_data,
        output data_ack, data, rom_addr, busy
    );
endinterface

// File: rtl/lcd_page_buffer.sv
// Fetches the 8 pixel rows of one LCD page from the image ROM and streams them back out
// transposed into column bytes (bit0 = top row), paced by the controller's lcd_en phases.
module lcd_page_buffer #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_page_buffer_if.slave bus
);
    localparam int               IDX_W    = $clog2(COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        ACK,
        STREAM
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        rowCnt_q, rowCnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ack_q, ack_d;
    logic [COLS-1:0]   rows_q [8];
    logic [COLS-1:0]   rows_d [8];
    logic [IDX_W-1:0]  colSel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            rowCnt_q <= '0;
            idx_q    <= '0;
            ack_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            addr_q   <= addr_d;
            rowCnt_q <= rowCnt_d;
            idx_q    <= idx_d;
            ack_q    <= ack_d;
            for (int i = 0; i < 8; i++) begin
                rows_q[i] <= rows_d[i];
            end
        end
    end

    // ROM data lags the issued row by one cycle, so LOAD stores the previous row
    // and CAPTURE picks up row 7 after the last issue.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rowCnt_d = rowCnt_q;
        idx_d    = idx_q;
        for (int i = 0; i < 8; i++) begin
            rows_d[i] = rows_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (bus.data_request) begin
                    addr_d   = bus.addr;
                    rowCnt_d = 3'd0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (rowCnt_q != 3'd0) begin
                    rows_d[rowCnt_q - 3'd1] = bus.rom_data;
                end
                if (rowCnt_q == 3'd7) begin
                    state_d = CAPTURE;
                end else begin
                    rowCnt_d = rowCnt_q + 3'd1;
                end
            end
            CAPTURE: begin
                rows_d[7] = bus.rom_data;
                state_d   = ACK;
            end
            ACK: begin
                if (!bus.data_request) begin
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!bus.lcd_en) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An aborted request still finishes the fetch but passes through ACK unacknowledged.
        ack_d = (state_d == ACK) && bus.data_request;
    end

    assign colSel = LAST_IDX - idx_q;

    always_comb begin
        bus.data = '0;
        for (int b = 0; b < 8; b++) begin
            bus.data[b] = rows_q[b][colSel];
        end
    end

    assign bus.rom_addr = {addr_q, rowCnt_q};
    assign bus.data_ack = ack_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_lcd_page_buffer.sv
// Directed bench for lcd_page_buffer: acts as LCD controller and image ROM, and checks
// fetch addressing, transposed byte stream, handshake timing, abort and reset behaviour.
module tb_lcd_page_buffer;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    int          assertCount = 0;
    int          failCount   = 0;
    int          romMode     = 0;
    logic [63:0] romDataQ    = '0;
    int          ackCycles;
    logic [8:0]  romTrace    [10];
    logic [7:0]  streamBytes [64];
    logic [7:0]  holdBytes   [64];
    logic        busyAtLast;
    logic        busyAfter;

    lcd_page_buffer_if #(.COLS(64), .ADDR_W(6)) bus ();

    lcd_page_buffer #(.COLS(64), .ADDR_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ROM patterns: 0 = diagonal (pixel x=r in row r), 1 = all ones, 2 = all zeros,
    // 3 = rows chosen so that column byte x reads {x[1:0], x[5:0] ^ page}.
    function automatic logic [63:0] romRow(input int mode, input logic [8:0] ra);
        logic [63:0] r;
        logic [5:0]  p;
        logic [5:0]  v;
        logic [1:0]  xl;
        int          row;
        r   = '0;
        p   = ra[8:3];
        row = int'(ra[2:0]);
        case (mode)
            0: r = 64'h1 << (63 - row);
            1: r = '1;
            2: r = '0;
            default: begin
                for (int x = 0; x < 64; x++) begin
                    v  = 6'(x) ^ p;
                    xl = 2'(x);
                    if (row < 6) r[63-x] = v[row];
                    else         r[63-x] = xl[row-6];
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [7:0] expByte(input int mode, input logic [5:0] p, input int y);
        case (mode)
            0:       return (y < 8) ? 8'(1 << y) : 8'h00;
            1:       return 8'hFF;
            2:       return 8'h00;
            default: return {2'(y), 6'(y) ^ p};
        endcase
    endfunction

    always @(posedge clk) romDataQ <= romRow(romMode, bus.rom_addr);
    assign bus.rom_data = romDataQ;

    task automatic startRequest(input logic [5:0] a);
        bus.data_request = 1'b1;
        bus.addr         = a;
    endtask

    // Counts edges until data_ack is seen (bounded), recording rom_addr each cycle.
    task automatic waitAck();
        ackCycles = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bus.lcd_en = ~bus.lcd_en;
            if (n <= 10) romTrace[n-1] = bus.rom_addr;
            if (bus.data_ack) begin
                ackCycles  = n;
                bus.lcd_en = 1'b0;
                break;
            end
        end
    endtask

    // Entered in the ack cycle T; drops the request at T+1 and samples byte y at T+2+2y.
    task automatic streamPage(input int pulseIdx, input logic [5:0] pulseAddr,
                              input bit chainNext, input logic [5:0] nextAddr);
        @(posedge clk); #1;
        bus.data_request = 1'b0;
        bus.lcd_en       = 1'b1;
        for (int y = 0; y < 64; y++) begin
            @(posedge clk); #1;
            bus.lcd_en     = 1'b0;
            streamBytes[y] = bus.data;
            if (y == pulseIdx) startRequest(pulseAddr);
            if (y == 63) begin
                busyAtLast = bus.busy;
                if (chainNext) startRequest(nextAddr);
            end
            @(posedge clk); #1;
            bus.lcd_en   = 1'b1;
            holdBytes[y] = bus.data;
            if (y == pulseIdx) bus.data_request = 1'b0;
            if (y == 63) busyAfter = bus.busy;
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.data_request = 1'b0;
        bus.addr         = '0;
        bus.lcd_en       = 1'b1;
        #12;
        assertCount++;
        if (bus.data_ack !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.data_ack); end
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        assertCount++;
        if (bus.rom_addr !== 9'h000) begin failCount++; $display("[TB] FAIL reset_rom_addr: got %h expected 000", bus.rom_addr); end
        assertCount++;
        if (bus.data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 00", bus.data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_idle: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_transpose();
        romMode = 0;
        @(posedge clk); #1;
        startRequest(6'h03);
        waitAck();
        assertCount++;
        if (ackCycles !== 10) begin failCount++; $display("[TB] FAIL transpose_ack_latency: got %0d expected 10", ackCycles); end
        for (int k = 0; k < 8; k++) begin
            assertCount++;
            if (romTrace[k] !== {6'h03, 3'(k)})
                begin failCount++; $display("[TB] FAIL transpose_rom_addr[%0d]: got %h expected %h", k, romTrace[k], {6'h03, 3'(k)}); end
        end
        streamPage(-1, 6'h00, 1'b0, 6'h00);
        for (int y = 0; y < 64; y++) begin
            assertCount++;
            if (streamBytes[y] !== expByte(0, 6'h03, y))
                begin failCount++; $display("[TB] FAIL transpose_byte[%0d]: got %h expected %h", y, streamBytes[y], expByte(0, 6'h03, y)); end
        end
    endtask

    task automatic test_handshake_timing();
        romMode = 3;
        @(posedge clk); #1;
        startRequest(6'h2C);
        waitAck();
        assertCount++;
        if (ackCycles !== 10) begin failCount++; $display("[TB] FAIL timing_ack_latency: got %0d expected 10", ackCycles); end
        streamPage(-1, 6'h00, 1'b0, 6'h00);
        for (int y = 0; y < 64; y++) begin
            assertCount++;
            if (streamBytes[y] !== expByte(3, 6'h2C, y))
                begin failCount++; $display("[TB] FAIL timing_byte[%0d]: got %h expected %h", y, streamBytes[y], expByte(3, 6'h2C, y)); end
            if (y < 63) begin
                assertCount++;
                if (holdBytes[y] !== expByte(3, 6'h2C, y + 1))
                    begin failCount++; $display("[TB] FAIL timing_hold[%0d]: got %h expected %h", y, holdBytes[y], expByte(3, 6'h2C, y + 1)); end
            end
        end
        assertCount++;
        if (busyAtLast !== 1'b1) begin failCount++; $display("[TB] FAIL timing_busy_last: got %b expected 1", busyAtLast); end
        assertCount++;
        if (busyAfter !== 1'b0) begin failCount++; $display("[TB] FAIL timing_busy_after: got %b expected 0", busyAfter); end
    endtask

    task automatic test_all_ones_zero();
        for (int m = 1; m <= 2; m++) begin
            romMode = m;
            @(posedge clk); #1;
            startRequest(6'(15 + m));
            waitAck();
            assertCount++;
            if (ackCycles !== 10) begin failCount++; $display("[TB] FAIL fill%0d_ack_latency: got %0d expected 10", m, ackCycles); end
            streamPage(-1, 6'h00, 1'b0, 6'h00);
            for (int y = 0; y < 64; y++) begin
                assertCount++;
                if (streamBytes[y] !== expByte(m, 6'h00, y))
                    begin failCount++; $display("[TB] FAIL fill%0d_byte[%0d]: got %h expected %h", m, y, streamBytes[y], expByte(m, 6'h00, y)); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        romMode = 1;
        @(posedge clk); #1;
        startRequest(6'h20);
        waitAck();
        streamPage(-1, 6'h00, 1'b0, 6'h00);
        startRequest(6'h21);
        repeat (4) begin @(posedge clk); #1; end
        assertCount++;
        if (bus.busy !== 1'b1) begin failCount++; $display("[TB] FAIL midload_busy_before: got %b expected 1", bus.busy); end
        assertCount++;
        if (bus.data !== 8'hFF) begin failCount++; $display("[TB] FAIL midload_data_before: got %h expected ff", bus.data); end
        #2;
        rst_n = 1'b0;
        #1;
        assertCount++;
        if (bus.data_ack !== 1'b0) begin failCount++; $display("[TB] FAIL midload_ack: got %b expected 0", bus.data_ack); end
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL midload_busy: got %b expected 0", bus.busy); end
        assertCount++;
        if (bus.rom_addr !== 9'h000) begin failCount++; $display("[TB] FAIL midload_rom_addr: got %h expected 000", bus.rom_addr); end
        assertCount++;
        if (bus.data !== 8'h00) begin failCount++; $display("[TB] FAIL midload_data: got %h expected 00", bus.data); end
        bus.data_request = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL midload_idle_after: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_abort();
        int ackHigh;
        int drainCycles;
        romMode    = 0;
        bus.lcd_en = 1'b1;
        @(posedge clk); #1;
        startRequest(6'h07);
        repeat (3) begin @(posedge clk); #1; end
        bus.data_request = 1'b0;
        ackHigh = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (bus.data_ack) ackHigh++;
        end
        assertCount++;
        if (ackHigh !== 0) begin failCount++; $display("[TB] FAIL abort_ack_cycles: got %0d expected 0", ackHigh); end
        assertCount++;
        if (bus.busy !== 1'b1) begin failCount++; $display("[TB] FAIL abort_busy_streaming: got %b expected 1", bus.busy); end
        bus.lcd_en = 1'b0;
        assertCount++;
        if (bus.data !== 8'h01) begin failCount++; $display("[TB] FAIL abort_byte0: got %h expected 01", bus.data); end
        drainCycles = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin drainCycles = n; break; end
        end
        bus.lcd_en = 1'b1;
        assertCount++;
        if (drainCycles !== 64) begin failCount++; $display("[TB] FAIL abort_drain_cycles: got %0d expected 64", drainCycles); end
    endtask

    task automatic test_ignored_request();
        romMode = 3;
        @(posedge clk); #1;
        startRequest(6'h05);
        waitAck();
        assertCount++;
        if (ackCycles !== 10) begin failCount++; $display("[TB] FAIL ignored_ack_latency: got %0d expected 10", ackCycles); end
        streamPage(10, 6'h2A, 1'b0, 6'h00);
        for (int y = 0; y < 64; y++) begin
            assertCount++;
            if (streamBytes[y] !== expByte(3, 6'h05, y))
                begin failCount++; $display("[TB] FAIL ignored_byte[%0d]: got %h expected %h", y, streamBytes[y], expByte(3, 6'h05, y)); end
        end
        assertCount++;
        if (busyAfter !== 1'b0) begin failCount++; $display("[TB] FAIL ignored_busy_after: got %b expected 0", busyAfter); end
        assertCount++;
        if (bus.rom_addr !== 9'h02F) begin failCount++; $display("[TB] FAIL ignored_addr_kept: got %h expected 02f", bus.rom_addr); end
        startRequest(6'h15);
        waitAck();
        assertCount++;
        if (romTrace[0] !== 9'h0A8) begin failCount++; $display("[TB] FAIL ignored_next_addr: got %h expected 0a8", romTrace[0]); end
        streamPage(-1, 6'h00, 1'b0, 6'h00);
        for (int y = 0; y < 64; y++) begin
            assertCount++;
            if (streamBytes[y] !== expByte(3, 6'h15, y))
                begin failCount++; $display("[TB] FAIL ignored_next_byte[%0d]: got %h expected %h", y, streamBytes[y], expByte(3, 6'h15, y)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pg;
        romMode = 3;
        @(posedge clk); #1;
        startRequest(6'h10);
        for (int i = 0; i < 16; i++) begin
            pg = 6'(16 + i);
            waitAck();
            assertCount++;
            if (ackCycles !== 10) begin failCount++; $display("[TB] FAIL b2b_ack_latency[%0d]: got %0d expected 10", i, ackCycles); end
            assertCount++;
            if (romTrace[0] !== {pg, 3'd0}) begin failCount++; $display("[TB] FAIL b2b_rom_first[%0d]: got %h expected %h", i, romTrace[0], {pg, 3'd0}); end
            assertCount++;
            if (romTrace[7] !== {pg, 3'd7}) begin failCount++; $display("[TB] FAIL b2b_rom_last[%0d]: got %h expected %h", i, romTrace[7], {pg, 3'd7}); end
            streamPage(-1, 6'h00, (i < 15), 6'(17 + i));
            for (int y = 0; y < 64; y++) begin
                assertCount++;
                if (streamBytes[y] !== expByte(3, pg, y))
                    begin failCount++; $display("[TB] FAIL b2b_byte[%0d][%0d]: got %h expected %h", i, y, streamBytes[y], expByte(3, pg, y)); end
            end
            assertCount++;
            if (busyAfter !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_busy_after[%0d]: got %b expected 0", i, busyAfter); end
        end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_handshake_timing();
        test_all_ones_zero();
        test_reset_mid_load();
        test_abort();
        test_ignored_request();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
